// File: rtl/hls_txn_monitor.sv
// Per-channel ap_ctrl transaction monitor.
// Each channel runs its own FSM and keeps its own transaction count,
// latency statistics and stall count. A finish request freezes all
// state, and clear resets it. Statistics are read back one field at a
// time through a registered readout port.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction in flight
// BUSY      | started, waiting for ap_done; latency counter running
// DONE_WAIT | ap_done seen, waiting for ap_continue; latency held, stalls counted
module hls_txn_monitor #(
    parameter int NUM_CH = 11,
    parameter int LAT_W  = 16,
    parameter int CNT_W  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_field,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] busy,
    output logic              frozen
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        DONE_WAIT = 2'd2
    } ch_state_t;

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    ch_state_t         state_q  [NUM_CH];
    ch_state_t         state_d  [NUM_CH];
    logic [LAT_W-1:0]  lat_q    [NUM_CH];
    logic [LAT_W-1:0]  lat_d    [NUM_CH];
    logic [LAT_W-1:0]  done_lat [NUM_CH];
    logic [NUM_CH-1:0] complete;
    logic [NUM_CH-1:0] stall_inc;

    logic [CNT_W-1:0]  txn_q    [NUM_CH];
    logic [CNT_W-1:0]  stall_q  [NUM_CH];
    logic [LAT_W-1:0]  min_q    [NUM_CH];
    logic [LAT_W-1:0]  max_q    [NUM_CH];
    logic [LAT_W-1:0]  last_q   [NUM_CH];

    logic [CNT_W-1:0]  rd_mux;

    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, latency and completion decode for every channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            lat_d[i]     = lat_q[i];
            done_lat[i]  = lat_q[i];
            complete[i]  = 1'b0;
            stall_inc[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (ap_start[i]) begin
                        lat_d[i] = LAT_W'(1);
                        if (ap_done[i]) begin
                            // Single-cycle transaction: the start is consumed here.
                            done_lat[i] = LAT_W'(1);
                            if (ap_continue[i]) complete[i] = 1'b1;
                            else                state_d[i]  = DONE_WAIT;
                        end else begin
                            state_d[i] = BUSY;
                        end
                    end
                end
                BUSY: begin
                    lat_d[i] = sat_lat(lat_q[i]);
                    if (ap_done[i]) begin
                        done_lat[i] = sat_lat(lat_q[i]);
                        if (ap_continue[i]) begin
                            complete[i] = 1'b1;
                            if (ap_start[i]) begin
                                state_d[i] = BUSY;
                                lat_d[i]   = LAT_W'(1);
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end else begin
                            state_d[i] = DONE_WAIT;
                        end
                    end
                end
                DONE_WAIT: begin
                    stall_inc[i] = 1'b1;
                    if (ap_continue[i]) begin
                        complete[i] = 1'b1;
                        if (ap_start[i]) begin
                            state_d[i] = BUSY;
                            lat_d[i]   = LAT_W'(1);
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // FSM and latency registers plus the sticky freeze flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
            end
            frozen <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
            end
            frozen <= 1'b0;
        end else if (!frozen) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
            end
            frozen <= finish;
        end
    end

    // Statistics update on completion and for every stalled cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                txn_q[i]   <= '0;
                stall_q[i] <= '0;
                min_q[i]   <= '1;
                max_q[i]   <= '0;
                last_q[i]  <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                txn_q[i]   <= '0;
                stall_q[i] <= '0;
                min_q[i]   <= '1;
                max_q[i]   <= '0;
                last_q[i]  <= '0;
            end
        end else if (!frozen) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stall_inc[i]) stall_q[i] <= sat_cnt(stall_q[i]);
                if (complete[i]) begin
                    txn_q[i]  <= sat_cnt(txn_q[i]);
                    last_q[i] <= done_lat[i];
                    if (done_lat[i] < min_q[i]) min_q[i] <= done_lat[i];
                    if (done_lat[i] > max_q[i]) max_q[i] <= done_lat[i];
                end
            end
        end
    end

    // A channel is busy whenever it is not idle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (state_q[i] != IDLE);
        end
    end

    // Readout field select; out-of-range channel or field reads as zero.
    always_comb begin
        rd_mux = '0;
        if ({1'b0, rd_ch} < NUM_CH_L) begin
            case (rd_field)
                3'd0: rd_mux = txn_q[rd_ch];
                3'd1: rd_mux = CNT_W'(min_q[rd_ch]);
                3'd2: rd_mux = CNT_W'(max_q[rd_ch]);
                3'd3: rd_mux = CNT_W'(last_q[rd_ch]);
                3'd4: rd_mux = stall_q[rd_ch];
                3'd5: rd_mux = {{(CNT_W-2){1'b0}}, state_q[rd_ch]};
                default: rd_mux = '0;
            endcase
        end
    end

    // Registered readout; rd_data keeps its last value between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_hls_txn_monitor.sv
// Directed bench for hls_txn_monitor: drives ap_ctrl handshakes, keeps a
// per-channel statistics model and checks readouts through a scoreboard.
module tb_hls_txn_monitor;

    localparam int NUM_CH = 11;
    localparam int LAT_W  = 16;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 4;

    logic              clock;
    logic              reset;
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic              finish;
    logic              clear;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [2:0]        rd_field;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH-1:0] busy;
    logic              frozen;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [31:0] m_txn   [NUM_CH];
    logic [31:0] m_stall [NUM_CH];
    logic [15:0] m_min   [NUM_CH];
    logic [15:0] m_max   [NUM_CH];
    logic [15:0] m_last  [NUM_CH];

    hls_txn_monitor #(
        .NUM_CH(NUM_CH),
        .LAT_W (LAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_continue(ap_continue),
        .finish     (finish),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_field   (rd_field),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy),
        .frozen     (frozen)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_txn[i]   = 32'd0;
            m_stall[i] = 32'd0;
            m_min[i]   = 16'hFFFF;
            m_max[i]   = 16'd0;
            m_last[i]  = 16'd0;
        end
    endtask

    task automatic record(input int ch, input int lat, input int stall);
        logic [15:0] l;
        l = 16'(lat);
        m_txn[ch]   = m_txn[ch] + 32'd1;
        m_stall[ch] = m_stall[ch] + 32'(stall);
        m_last[ch]  = l;
        if (l < m_min[ch]) m_min[ch] = l;
        if (l > m_max[ch]) m_max[ch] = l;
    endtask

    // Issue one read, push its expectation, and pop/compare when rd_valid shows.
    task automatic rd(input int ch, input int fld, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        int          waited;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        rd_en    = 1'b1;
        rd_ch    = CH_W'(ch);
        rd_field = 3'(fld);
        step();
        rd_en  = 1'b0;
        waited = 0;
        while (rd_valid !== 1'b1 && waited < 3) begin
            step();
            waited++;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check($sformatf("%s_valid", t), 32'(rd_valid), 32'd1);
        if (rd_valid === 1'b1) check(t, rd_data, e);
    endtask

    task automatic check_ch(input int ch, input string pfx);
        rd(ch, 0, m_txn[ch],             $sformatf("%s_ch%0d_txn", pfx, ch));
        rd(ch, 1, {16'h0, m_min[ch]},    $sformatf("%s_ch%0d_min", pfx, ch));
        rd(ch, 2, {16'h0, m_max[ch]},    $sformatf("%s_ch%0d_max", pfx, ch));
        rd(ch, 3, {16'h0, m_last[ch]},   $sformatf("%s_ch%0d_last", pfx, ch));
        rd(ch, 4, m_stall[ch],           $sformatf("%s_ch%0d_stall", pfx, ch));
        rd(ch, 5, 32'd0,                 $sformatf("%s_ch%0d_state", pfx, ch));
    endtask

    // One transaction of len cycles (start..done inclusive) with stall DONE_WAIT cycles.
    task automatic run_txn(input int ch, input int len, input int stall);
        ap_start[ch] = 1'b1;
        if (len == 1) begin
            ap_done[ch]     = 1'b1;
            ap_continue[ch] = (stall == 0);
            step();
            ap_start[ch] = 1'b0;
            ap_done[ch]  = 1'b0;
        end else begin
            step();
            ap_start[ch] = 1'b0;
            check($sformatf("busy_start_ch%0d", ch), 32'(busy[ch]), 32'd1);
            repeat (len - 2) step();
            check($sformatf("busy_pre_done_ch%0d", ch), 32'(busy[ch]), 32'd1);
            ap_done[ch]     = 1'b1;
            ap_continue[ch] = (stall == 0);
            step();
            ap_done[ch] = 1'b0;
        end
        if (stall > 0) begin
            if (stall >= 2) begin
                rd(ch, 5, 32'd2, $sformatf("stall_state_ch%0d", ch));
                repeat (stall - 2) step();
            end
            ap_continue[ch] = 1'b1;
            step();
        end
        check($sformatf("busy_end_ch%0d", ch), 32'(busy[ch]), 32'd0);
        record(ch, len, stall);
    endtask

    initial begin
        logic [NUM_CH-1:0] mask;

        reset       = 1'b0;
        ap_start    = '0;
        ap_done     = '0;
        ap_continue = '1;
        finish      = 1'b0;
        clear       = 1'b0;
        rd_en       = 1'b1;
        rd_ch       = '0;
        rd_field    = 3'd0;
        model_reset();

        repeat (3) step();
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_frozen",   32'(frozen), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data",  rd_data, 32'd0);
        rd_en = 1'b0;
        reset = 1'b1;
        step();
        check_ch(0, "rst");

        // Ch0: plain 5-cycle transaction.
        run_txn(0, 5, 0);
        check_ch(0, "c0");

        // Ch1: 4-cycle transaction followed by 3 stall cycles.
        run_txn(1, 4, 3);
        check_ch(1, "c1");

        // Ch2: back-to-back transactions of 4, 6 and 3 cycles.
        ap_start[2] = 1'b1;
        step();
        ap_start[2] = 1'b0;
        repeat (2) step();
        ap_done[2] = 1'b1; ap_start[2] = 1'b1;
        step();
        ap_done[2] = 1'b0; ap_start[2] = 1'b0;
        repeat (4) step();
        ap_done[2] = 1'b1; ap_start[2] = 1'b1;
        step();
        ap_done[2] = 1'b0; ap_start[2] = 1'b0;
        step();
        ap_done[2] = 1'b1;
        step();
        ap_done[2] = 1'b0;
        record(2, 4, 0);
        record(2, 6, 0);
        record(2, 3, 0);
        check_ch(2, "c2");

        // Start and done in the same idle cycle, with and without continue.
        run_txn(5, 1, 0);
        check_ch(5, "c5");
        run_txn(6, 1, 2);
        check_ch(6, "c6");

        // All channels start together; channel i runs for 2+i cycles.
        ap_start = '1;
        step();
        ap_start = '0;
        check("all_busy", 32'(busy), 32'(11'h7FF));
        for (int k = 1; k <= NUM_CH; k++) begin
            mask = '0;
            for (int i = 0; i < NUM_CH; i++) if (2 + i - 1 == k) mask[i] = 1'b1;
            ap_done = mask;
            step();
        end
        ap_done = '0;
        check("all_idle", 32'(busy), 32'd0);
        for (int i = 0; i < NUM_CH; i++) record(i, 2 + i, 0);
        for (int i = 0; i < NUM_CH; i++) check_ch(i, "all");

        rd(11, 0, 32'd0, "oor_ch");
        rd(0, 6, 32'd0, "oor_field6");
        rd(0, 7, 32'd0, "oor_field7");

        // Freeze mid-transaction on ch3, then poke its ap_done.
        ap_start[3] = 1'b1;
        step();
        ap_start[3] = 1'b0;
        step();
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("frz_frozen", 32'(frozen), 32'd1);
        repeat (4) begin
            ap_done[3] = ~ap_done[3];
            step();
        end
        ap_done[3]  = 1'b0;
        ap_start[7] = 1'b1;
        step();
        ap_start[7] = 1'b0;
        check("frz_busy3", 32'(busy[3]), 32'd1);
        check("frz_busy7", 32'(busy[7]), 32'd0);
        rd(3, 0, m_txn[3],          "frz_ch3_txn");
        rd(3, 3, {16'h0, m_last[3]}, "frz_ch3_last");
        rd(3, 5, 32'd1,             "frz_ch3_state");
        check("frz_still", 32'(frozen), 32'd1);

        // Clear wipes statistics and the freeze.
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        check("clr_frozen", 32'(frozen), 32'd0);
        check("clr_busy",   32'(busy), 32'd0);
        for (int i = 0; i < NUM_CH; i++) check_ch(i, "clr");

        // Reset during BUSY on ch4 discards the transaction.
        run_txn(0, 3, 0);
        ap_start[4] = 1'b1;
        step();
        ap_start[4] = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        #2;
        check("rstmid_busy",     32'(busy), 32'd0);
        check("rstmid_rd_valid", 32'(rd_valid), 32'd0);
        step();
        reset = 1'b1;
        model_reset();
        step();
        run_txn(4, 2, 0);
        check_ch(4, "rstmid");
        check_ch(0, "rstmid");

        step();
        check("idle_rd_valid", 32'(rd_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
